viterbi_decoder_k4: RTL
=======================

# viterbi_decoder_k4

Hard-decision Viterbi decoder for the rate-1/2, K=4 convolutional code (generators 17/15 octal) produced by the team's K=4 encoder. It sits directly downstream of the encoder's 2-bit symbol output, after the channel. It accepts one code symbol per cycle and uses register-exchange survivor paths. It emits one decoded bit per accepted symbol, delayed by a fixed traceback depth.

## Interface
- TB_DEPTH, 20: survivor path length in bits (>=4); sets decode latency.
- PM_W, 6: path-metric width in bits; metrics saturate at 2^PM_W-1.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  frame start; re-initialises metrics, paths and the symbol counter.
- in_valid  input  1  in_sym is valid this cycle; every valid symbol is accepted, with no backpressure.
- in_sym  input  2  received symbol {c1,c0}, in the same bit order as the encoder output (bit1 = G 17, bit0 = G 15).
- out_valid  output  1  out_bit holds a decoded bit; single-cycle pulse.
- out_bit  output  1  decoded information bit.

## Operation
- State S[2:0] = {u(n-1), u(n-2), u(n-3)}, which matches the encoder shift register. Input u moves S to {u, S[2], S[1]}.
- Expected symbol for (S,u):
  - c1 = u^S2^S1^S0
  - c0 = u^S2^S0
- Branch metric = popcount(in_sym ^ {c1,c0}), giving a value of 0..2.
- ACS for next state N: the predecessors are {N[1:0],0} and {N[1:0],1}, with u = N[2].
  - Each candidate is PM(pred) + BM, saturating.
  - The smaller candidate wins. On a tie, the predecessor with LSB 0 wins.
- Normalisation: after ACS, subtract the minimum of the 8 new metrics from all 8, so the minimum stored metric is always 0.
- Survivors: path[N] <= {path[winner][TB_DEPTH-2:0], N[2]}. The LSB is the newest bit.
- Output selection, evaluated on the pre-update registers at each accepted symbol:
  - best = lowest-index state with metric 0.
  - out_bit <= path[best][TB_DEPTH-1].
- Initialisation (on reset or start):
  - PM[0] = 0 and PM[1..7] = 2^(PM_W-2).
  - All paths = 0.
  - Symbol counter = 0.
- The counter saturates at TB_DEPTH. out_valid <= in_valid && count == TB_DEPTH.
- start with in_valid in the same cycle: initialisation is applied first, then that symbol is processed as symbol 0 of the new frame. out_valid is 0 in that cycle, and undelivered bits from the old frame are discarded.
- start without in_valid: initialise only, with no ACS step.
- in_valid low: metrics, paths and counter hold, and out_valid <= 0.
- Flushing: the upstream sends 3 zero tail bits and then keeps sending encoded zeros until the last wanted bit has emerged. The decoder has no internal flush.

## Timing
- Reset values: out_valid = 0 and out_bit = 0. Metrics, paths and counter take their initialisation values.
- Registered outputs: the decoded bit for symbol j is registered on the edge that accepts symbol j+TB_DEPTH.
  - With continuous input, it is visible TB_DEPTH cycles after symbol j is presented.
- The first out_valid of a frame follows acceptance of symbol TB_DEPTH (0-indexed).
- Reset asserted mid-frame clears everything immediately and asynchronously. The first symbol after release is symbol 0.
- Throughput: one symbol per cycle, sustained, with no bubbles.

## Structure
- Package viterbi_k4_pkg holds:
  - K=4 and NUM_STATES=8.
  - G1=4'b1111 and G0=4'b1101.
  - A function expected_sym(state, u) and a function for the branch-metric popcount.
- Sub-module viterbi_acs_unit, one instance per next state:
  - Inputs: two predecessor metrics and two branch metrics.
  - Outputs: the saturated winning metric and the decision bit.
- The top level contains the normalisation, survivor registers, best-state search, counter and output registers.

## Test plan
- Error-free vector, TB_DEPTH=20: symbols 11,11,01,11,01,01,11 followed by 20 symbols of 00. Outputs start 1,0,1,1,0,0,0, then zeros. The first out_valid comes 20 cycles after the first symbol.
- Single error: the same vector with symbol 2 corrupted to 00. The decoded output is identical to the error-free case.
- All-zero stream of 100 symbols with one bit flipped every 10 symbols: the output is all 0. Metrics never saturate, and after normalisation min(PM) = 0 every cycle.
- in_valid gaps: the error-free vector with 3 idle cycles inserted between each pair of symbols. The output bits and their order are unchanged, and out_valid pulses only in cycles following an accepted symbol.
- start asserted with in_valid at symbol 30 of a random stream, followed by a new encoded frame: no out_valid for the next 20 accepted symbols, then the new frame's bits are correct.
- rst pulsed low for 1 cycle mid-frame: out_valid drops to 0 immediately. Decoding of a fresh frame started after release is correct and has the full latency.

Source files
------------

// File: rtl/viterbi_k4_pkg.sv
// Shared constants and helpers for the K=4, rate-1/2 (17/15 octal) hard-decision Viterbi decoder.
package viterbi_k4_pkg;
    localparam int K = 4;
    localparam int NUM_STATES = 8;
    localparam logic [3:0] G1 = 4'b1111;
    localparam logic [3:0] G0 = 4'b1101;

    // Taps are applied to {u, S2, S1, S0}, matching the encoder shift register.
    function automatic logic [1:0] expected_sym(input logic [2:0] state, input logic u);
        logic [3:0] sr;
        sr = {u, state};
        return {^(sr & G1), ^(sr & G0)};
    endfunction

    function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] ref_sym);
        logic [1:0] d;
        d = rx ^ ref_sym;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction
endpackage

// File: rtl/viterbi_acs_unit.sv
// Add-compare-select for one trellis state; saturating add, ties go to the LSB-0 predecessor.
module viterbi_acs_unit #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] pm_out,
    output logic            dec
);
    logic [PM_W:0]   sum0, sum1;
    logic [PM_W-1:0] cand0, cand1;

    always_comb begin
        sum0   = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
        sum1   = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};
        cand0  = sum0[PM_W] ? '1 : sum0[PM_W-1:0];
        cand1  = sum1[PM_W] ? '1 : sum1[PM_W-1:0];
        dec    = (cand1 < cand0);
        pm_out = dec ? cand1 : cand0;
    end
endmodule

// File: rtl/viterbi_decoder_k4.sv
// Hard-decision Viterbi decoder, register-exchange survivors, one symbol in / one bit out per cycle.
module viterbi_decoder_k4
    import viterbi_k4_pkg::*;
#(
    parameter int TB_DEPTH = 20,
    parameter int PM_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [1:0] in_sym,
    output logic       out_valid,
    output logic       out_bit
);
    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

    logic [NUM_STATES-1:0][PM_W-1:0]     pm, src_pm, acs_pm, pm_next;
    logic [NUM_STATES-1:0][TB_DEPTH-1:0] path, src_path, path_next;
    logic [NUM_STATES-1:0]               dec;
    logic [PM_W-1:0]                     pm_min;
    logic [2:0]                          best;
    logic [CNT_W-1:0]                    cnt;

    // A start in the same cycle as a symbol feeds the ACS from the initial state.
    always_comb begin
        for (int i = 0; i < NUM_STATES; i++)
            src_pm[i] = start ? ((i == 0) ? '0 : PM_INIT) : pm[i];
        src_path = start ? '0 : path;
    end

    for (genvar n = 0; n < NUM_STATES; n++) begin : g_state
        localparam logic [2:0] P0 = 3'((n % 4) * 2);
        localparam logic [2:0] P1 = P0 | 3'd1;
        localparam logic       U  = (n >= 4);
        logic [1:0] bm0, bm1;

        assign bm0 = branch_metric(in_sym, expected_sym(P0, U));
        assign bm1 = branch_metric(in_sym, expected_sym(P1, U));

        viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
            .pm0    (src_pm[P0]),
            .pm1    (src_pm[P1]),
            .bm0    (bm0),
            .bm1    (bm1),
            .pm_out (acs_pm[n]),
            .dec    (dec[n])
        );

        assign path_next[n] = {dec[n] ? src_path[P1][TB_DEPTH-2:0] : src_path[P0][TB_DEPTH-2:0], U};
    end

    always_comb begin
        pm_min = acs_pm[0];
        for (int i = 1; i < NUM_STATES; i++)
            if (acs_pm[i] < pm_min) pm_min = acs_pm[i];
        for (int i = 0; i < NUM_STATES; i++)
            pm_next[i] = acs_pm[i] - pm_min;
    end

    // Normalised metrics guarantee at least one zero; take the lowest such index.
    always_comb begin
        best = '0;
        for (int i = NUM_STATES - 1; i >= 0; i--)
            if (pm[i] == '0) best = 3'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_STATES; i++)
                pm[i] <= (i == 0) ? '0 : PM_INIT;
            path      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else begin
            out_valid <= in_valid && !start && (cnt == CNT_W'(TB_DEPTH));
            if (in_valid) begin
                pm   <= pm_next;
                path <= path_next;
                if (start)
                    cnt <= CNT_W'(1);
                else if (cnt != CNT_W'(TB_DEPTH))
                    cnt <= cnt + 1'b1;
                if (!start)
                    out_bit <= path[best][TB_DEPTH-1];
            end else if (start) begin
                pm   <= src_pm;
                path <= src_path;
                cnt  <= '0;
            end
        end
    end
endmodule
